// File: rtl/mpi_slave.sv
// MPI (Q-bus style) bus slave: answers DATI/DATO/DATOB cycles in a decoded window and bridges
// them to a word-wide req/ack memory port. Define MPI_SLAVE_RMW_EN to serve DATIO/DATIOB.
module mpi_slave #(
   parameter logic [15:0] BASE_ADDR = 16'o100000,
   parameter logic [15:0] ADDR_MASK = 16'o160000,
   parameter int unsigned MEM_AW    = 12
) (
   input  logic              clk,
   input  logic              init,
   input  logic              sync,
   input  logic              din,
   input  logic              dout,
   input  logic              wtbt,
   output logic              rply,
   inout  wire  [15:0]       ad,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic [1:0]        mem_be,
   output logic              mem_we,
   output logic              mem_re,
   input  logic              mem_ack,
   input  logic [15:0]       mem_rdata
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SEL     = 3'd1;
   localparam logic [2:0] S_RD_MEM  = 3'd2;
   localparam logic [2:0] S_RD_RPLY = 3'd3;
   localparam logic [2:0] S_WR_MEM  = 3'd4;
   localparam logic [2:0] S_WR_RPLY = 3'd5;
   localparam logic [2:0] S_DONE    = 3'd6;

   logic [2:0]        state_q, state_d;
   logic              sync_q;
   logic              abort_q, abort_d;
   logic [MEM_AW:0]   addr_q, addr_d;
   logic [15:0]       rdata_q, rdata_d;
   logic              rply_q, rply_d;
   logic              ad_oe_q, ad_oe_d;
   logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
   logic [15:0]       mem_wdata_q, mem_wdata_d;
   logic [1:0]        mem_be_q, mem_be_d;
   logic              mem_we_q, mem_we_d;
   logic              mem_re_q, mem_re_d;

   always_comb begin
      state_d     = state_q;
      abort_d     = abort_q;
      addr_d      = addr_q;
      rdata_d     = rdata_q;
      rply_d      = rply_q;
      ad_oe_d     = ad_oe_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      mem_we_d    = mem_we_q;
      mem_re_d    = mem_re_q;
      case (state_q)
         S_IDLE: begin
            abort_d = 1'b0;
            if (sync && !sync_q) begin
               addr_d = ad[MEM_AW:0];
               if ((ad & ADDR_MASK) == BASE_ADDR) state_d = S_SEL;
            end
         end
         S_SEL: begin
            if (!sync) begin
               state_d = S_IDLE;
            end else if (din) begin
               state_d    = S_RD_MEM;
               mem_re_d   = 1'b1;
               mem_addr_d = addr_q[MEM_AW:1];
               mem_be_d   = 2'b11;
            end else if (dout) begin
               state_d     = S_WR_MEM;
               mem_we_d    = 1'b1;
               mem_addr_d  = addr_q[MEM_AW:1];
               mem_wdata_d = ad;
               mem_be_d    = wtbt ? (addr_q[0] ? 2'b10 : 2'b01) : 2'b11;
            end
         end
         // A cycle abandoned by the master must still wait for the memory handshake,
         // and a new sync arriving meanwhile must not revive the old cycle.
         S_RD_MEM, S_WR_MEM: begin
            if (!sync) abort_d = 1'b1;
            if (mem_ack) begin
               mem_re_d = 1'b0;
               mem_we_d = 1'b0;
               if (state_q == S_RD_MEM) rdata_d = mem_rdata;
               if (sync && !abort_q)
                  state_d = (state_q == S_RD_MEM) ? S_RD_RPLY : S_WR_RPLY;
               else
                  state_d = S_IDLE;
            end
         end
         S_RD_RPLY: begin
            if (!sync) begin
               rply_d  = 1'b0;
               ad_oe_d = 1'b0;
               state_d = S_IDLE;
            end else if (!rply_q) begin
               rply_d  = 1'b1;
               ad_oe_d = 1'b1;
            end else if (!din) begin
               rply_d  = 1'b0;
               ad_oe_d = 1'b0;
`ifdef MPI_SLAVE_RMW_EN
               state_d = S_SEL;
`else
               state_d = S_DONE;
`endif
            end
         end
         S_WR_RPLY: begin
            if (!sync) begin
               rply_d  = 1'b0;
               state_d = S_IDLE;
            end else if (!rply_q) begin
               rply_d  = 1'b1;
            end else if (!dout) begin
               rply_d  = 1'b0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (!sync) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (init) begin
         state_q     <= S_IDLE;
         sync_q      <= 1'b0;
         abort_q     <= 1'b0;
         addr_q      <= '0;
         rdata_q     <= '0;
         rply_q      <= 1'b0;
         ad_oe_q     <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync;
         abort_q     <= abort_d;
         addr_q      <= addr_d;
         rdata_q     <= rdata_d;
         rply_q      <= rply_d;
         ad_oe_q     <= ad_oe_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         mem_we_q    <= mem_we_d;
         mem_re_q    <= mem_re_d;
      end
   end

   assign ad        = ad_oe_q ? rdata_q : {16{1'bz}};
   assign rply      = rply_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign mem_we    = mem_we_q;
   assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_mpi_slave.sv
// Directed bench for mpi_slave; ad has pull-ups so a released bus reads 16'hFFFF.
module tb_mpi_slave;

   logic        clk = 1'b0;
   logic        init = 1'b1;
   logic        sync = 1'b0, din = 1'b0, dout = 1'b0, wtbt = 1'b0;
   logic        rply;
   wire  [15:0] ad;
   logic [15:0] tb_ad = '0;
   logic        tb_oe = 1'b0;
   logic [11:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [1:0]  mem_be;
   logic        mem_we, mem_re;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_rdata = '0;

   int n_cmp = 0;
   int n_bad = 0;

   mpi_slave #(.BASE_ADDR(16'o100000), .ADDR_MASK(16'o160000), .MEM_AW(12)) dut (
      .clk(clk), .init(init), .sync(sync), .din(din), .dout(dout), .wtbt(wtbt),
      .rply(rply), .ad(ad), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_we(mem_we), .mem_re(mem_re), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   assign ad = tb_oe ? tb_ad : {16{1'bz}};
   for (genvar g = 0; g < 16; g++) begin : g_pu
      pullup (ad[g]);
   end

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic addr_phase(input logic [15:0] a);
      tb_ad = a;
      tb_oe = 1'b1;
      sync  = 1'b1;
      tick();
      tb_oe = 1'b0;
   endtask

   task automatic end_cycle;
      din = 1'b0; dout = 1'b0; wtbt = 1'b0; tb_oe = 1'b0; sync = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset;
      init = 1'b1;
      tick();
      tick();
      init = 1'b0;
      n_cmp++; if (rply !== 1'b0) begin n_bad++; $display("FAIL reset_rply got=%b exp=0", rply); end
      n_cmp++; if (ad !== 16'hFFFF) begin n_bad++; $display("FAIL reset_ad got=%h exp=ffff", ad); end
      n_cmp++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%b%b exp=00", mem_we, mem_re); end
      n_cmp++; if (mem_be !== 2'b00) begin n_bad++; $display("FAIL reset_be got=%b exp=00", mem_be); end
      n_cmp++; if (mem_addr !== 12'd0 || mem_wdata !== 16'h0) begin n_bad++; $display("FAIL reset_addr_wdata got=%h/%h exp=0/0", mem_addr, mem_wdata); end
   endtask

   task automatic test_dati;
      addr_phase(16'o100004);
      din = 1'b1;
      tick();
      n_cmp++; if (mem_re !== 1'b1) begin n_bad++; $display("FAIL dati_re got=%b exp=1", mem_re); end
      n_cmp++; if (mem_addr !== 12'd2) begin n_bad++; $display("FAIL dati_addr got=%h exp=002", mem_addr); end
      mem_rdata = 16'h1234; mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      n_cmp++; if (mem_re !== 1'b0) begin n_bad++; $display("FAIL dati_re_drop got=%b exp=0", mem_re); end
      n_cmp++; if (rply !== 1'b0) begin n_bad++; $display("FAIL dati_rply_early got=%b exp=0", rply); end
      tick();
      n_cmp++; if (rply !== 1'b1) begin n_bad++; $display("FAIL dati_rply got=%b exp=1", rply); end
      n_cmp++; if (ad !== 16'h1234) begin n_bad++; $display("FAIL dati_ad got=%h exp=1234", ad); end
      repeat (3) tick();
      n_cmp++; if (rply !== 1'b1 || ad !== 16'h1234) begin n_bad++; $display("FAIL dati_hold got=%b/%h exp=1/1234", rply, ad); end
      din = 1'b0;
      tick();
      tick();
      n_cmp++; if (rply !== 1'b0) begin n_bad++; $display("FAIL dati_rply_release got=%b exp=0", rply); end
      n_cmp++; if (ad !== 16'hFFFF) begin n_bad++; $display("FAIL dati_ad_release got=%h exp=ffff", ad); end
      end_cycle();
   endtask

   task automatic test_datob;
      addr_phase(16'o100007);
      tb_ad = 16'hAB00; tb_oe = 1'b1; dout = 1'b1; wtbt = 1'b1;
      tick();
      n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL datob_we got=%b exp=1", mem_we); end
      n_cmp++; if (mem_be !== 2'b10) begin n_bad++; $display("FAIL datob_be got=%b exp=10", mem_be); end
      n_cmp++; if (mem_wdata !== 16'hAB00) begin n_bad++; $display("FAIL datob_wdata got=%h exp=ab00", mem_wdata); end
      n_cmp++; if (mem_addr !== 12'd3) begin n_bad++; $display("FAIL datob_addr got=%h exp=003", mem_addr); end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      n_cmp++; if (mem_we !== 1'b0 || rply !== 1'b0) begin n_bad++; $display("FAIL datob_ack got=we%b rply%b exp=we0 rply0", mem_we, rply); end
      tick();
      n_cmp++; if (rply !== 1'b1) begin n_bad++; $display("FAIL datob_rply got=%b exp=1", rply); end
      dout = 1'b0;
      tick();
      tick();
      n_cmp++; if (rply !== 1'b0) begin n_bad++; $display("FAIL datob_rply_release got=%b exp=0", rply); end
      end_cycle();
   endtask

   task automatic test_dato_be;
      logic [15:0] a_tab   [2] = '{16'o100002, 16'o100012};
      logic [15:0] d_tab   [2] = '{16'h00C3, 16'h5A5A};
      logic        w_tab   [2] = '{1'b0, 1'b1};
      logic [1:0]  be_tab  [2] = '{2'b11, 2'b01};
      logic [11:0] ma_tab  [2] = '{12'd1, 12'd5};
      for (int i = 0; i < 2; i++) begin
         addr_phase(a_tab[i]);
         tb_ad = d_tab[i]; tb_oe = 1'b1; dout = 1'b1; wtbt = w_tab[i];
         tick();
         n_cmp++; if (mem_be !== be_tab[i]) begin n_bad++; $display("FAIL dato_be[%0d] got=%b exp=%b", i, mem_be, be_tab[i]); end
         n_cmp++; if (mem_addr !== ma_tab[i] || mem_wdata !== d_tab[i]) begin n_bad++; $display("FAIL dato_aw[%0d] got=%h/%h exp=%h/%h", i, mem_addr, mem_wdata, ma_tab[i], d_tab[i]); end
         mem_ack = 1'b1;
         tick();
         mem_ack = 1'b0;
         tick();
         n_cmp++; if (rply !== 1'b1) begin n_bad++; $display("FAIL dato_rply[%0d] got=%b exp=1", i, rply); end
         dout = 1'b0;
         tick();
         tick();
         end_cycle();
      end
   endtask

   task automatic test_out_of_window;
      addr_phase(16'o040000);
      din = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         n_cmp++; if (rply !== 1'b0 || mem_re !== 1'b0 || ad !== 16'hFFFF) begin n_bad++; $display("FAIL oow[%0d] got=rply%b re%b ad%h exp=rply0 re0 adffff", i, rply, mem_re, ad); end
      end
      end_cycle();
   endtask

   task automatic test_wait_states;
      addr_phase(16'o100020);
      din = 1'b1;
      tick();
      n_cmp++; if (mem_addr !== 12'd8) begin n_bad++; $display("FAIL ws_addr got=%h exp=008", mem_addr); end
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if (mem_re !== 1'b1 || rply !== 1'b0) begin n_bad++; $display("FAIL ws_wait[%0d] got=re%b rply%b exp=re1 rply0", i, mem_re, rply); end
         tick();
      end
      mem_rdata = 16'hBEEF; mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      n_cmp++; if (rply !== 1'b0 || mem_re !== 1'b0) begin n_bad++; $display("FAIL ws_ack got=rply%b re%b exp=rply0 re0", rply, mem_re); end
      tick();
      n_cmp++; if (rply !== 1'b1 || ad !== 16'hBEEF) begin n_bad++; $display("FAIL ws_rply got=%b/%h exp=1/beef", rply, ad); end
      din = 1'b0;
      tick();
      tick();
      end_cycle();
   endtask

   task automatic test_din_wins;
      addr_phase(16'o100004);
      din = 1'b1; dout = 1'b1;
      tick();
      n_cmp++; if (mem_re !== 1'b1 || mem_we !== 1'b0) begin n_bad++; $display("FAIL dinwins got=re%b we%b exp=re1 we0", mem_re, mem_we); end
      mem_rdata = 16'h2222; mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0; dout = 1'b0;
      tick();
      n_cmp++; if (rply !== 1'b1 || ad !== 16'h2222) begin n_bad++; $display("FAIL dinwins_rply got=%b/%h exp=1/2222", rply, ad); end
      end_cycle();
   endtask

   task automatic test_abort;
      addr_phase(16'o100004);
      din = 1'b1;
      tick();
      sync = 1'b0; din = 1'b0;
      tick();
      tick();
      n_cmp++; if (mem_re !== 1'b1 || rply !== 1'b0) begin n_bad++; $display("FAIL abort_hold got=re%b rply%b exp=re1 rply0", mem_re, rply); end
      mem_rdata = 16'h3333; mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      n_cmp++; if (mem_re !== 1'b0) begin n_bad++; $display("FAIL abort_re_drop got=%b exp=0", mem_re); end
      tick();
      n_cmp++; if (rply !== 1'b0 || ad !== 16'hFFFF) begin n_bad++; $display("FAIL abort_norply got=%b/%h exp=0/ffff", rply, ad); end
      addr_phase(16'o100010);
      din = 1'b1;
      tick();
      n_cmp++; if (mem_re !== 1'b1 || mem_addr !== 12'd4) begin n_bad++; $display("FAIL abort_next_req got=re%b addr%h exp=re1 addr004", mem_re, mem_addr); end
      mem_rdata = 16'h0F0F; mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      tick();
      n_cmp++; if (rply !== 1'b1 || ad !== 16'h0F0F) begin n_bad++; $display("FAIL abort_next_rply got=%b/%h exp=1/0f0f", rply, ad); end
      din = 1'b0;
      tick();
      tick();
      end_cycle();
   endtask

   task automatic test_rmw;
      addr_phase(16'o100002);
      din = 1'b1;
      tick();
      mem_rdata = 16'h1111; mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      tick();
      n_cmp++; if (rply !== 1'b1 || ad !== 16'h1111) begin n_bad++; $display("FAIL rmw_read got=%b/%h exp=1/1111", rply, ad); end
      din = 1'b0;
      tick();
      n_cmp++; if (rply !== 1'b0) begin n_bad++; $display("FAIL rmw_read_release got=%b exp=0", rply); end
      tb_ad = 16'h5555; tb_oe = 1'b1; dout = 1'b1; wtbt = 1'b0;
      tick();
`ifdef MPI_SLAVE_RMW_EN
      n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 12'd1) begin n_bad++; $display("FAIL rmw_write_req got=we%b addr%h exp=we1 addr001", mem_we, mem_addr); end
      n_cmp++; if (mem_wdata !== 16'h5555 || mem_be !== 2'b11) begin n_bad++; $display("FAIL rmw_write_data got=%h/%b exp=5555/11", mem_wdata, mem_be); end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      tick();
      n_cmp++; if (rply !== 1'b1) begin n_bad++; $display("FAIL rmw_write_rply got=%b exp=1", rply); end
      dout = 1'b0;
      tick();
      tick();
      n_cmp++; if (rply !== 1'b0) begin n_bad++; $display("FAIL rmw_write_release got=%b exp=0", rply); end
`else
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (rply !== 1'b0 || mem_we !== 1'b0) begin n_bad++; $display("FAIL rmw_ignored[%0d] got=rply%b we%b exp=rply0 we0", i, rply, mem_we); end
         tick();
      end
`endif
      end_cycle();
   endtask

   task automatic test_init_mid;
      addr_phase(16'o100004);
      din = 1'b1;
      tick();
      init = 1'b1;
      tick();
      n_cmp++; if (mem_re !== 1'b0 || rply !== 1'b0) begin n_bad++; $display("FAIL init_mid_req got=re%b rply%b exp=re0 rply0", mem_re, rply); end
      n_cmp++; if (mem_addr !== 12'd0 || mem_be !== 2'b00 || ad !== 16'hFFFF) begin n_bad++; $display("FAIL init_mid_state got=%h/%b/%h exp=000/00/ffff", mem_addr, mem_be, ad); end
      init = 1'b0;
      end_cycle();
   endtask

   initial begin
      test_reset();
      test_dati();
      test_datob();
      test_dato_be();
      test_out_of_window();
      test_wait_states();
      test_din_wins();
      test_abort();
      test_rmw();
      test_init_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
